button_bit_sampler: RTL and testbench
=====================================

BUTTON_BIT_SAMPLER -- requirements
Module: button_bit_sampler

Interface
REQ-001 The block SHALL use one clock, CLOCK; reset Rst SHALL be synchronous and active-high.
REQ-002 Parameter DEBOUNCE_CYCLES SHALL have default 1250000 and SHALL set the number of consecutive cycles an input must hold a new level before it is accepted.
REQ-003 Parameter CNT_W SHALL have default 21 and SHALL set the debounce counter width; it SHALL satisfy 2^CNT_W > DEBOUNCE_CYCLES.
REQ-004 Port CLOCK SHALL be an input, 1 bit wide: the system clock (125 MHz on the board).
REQ-005 Port Rst SHALL be an input, 1 bit wide: synchronous active-high reset.
REQ-006 Port dataSw SHALL be an input, 1 bit wide: raw, asynchronous data switch level.
REQ-007 Port shiftBtn SHALL be an input, 1 bit wide: raw, asynchronous push-button; each press enters one bit.
REQ-008 Port bitOut SHALL be an output, 1 bit wide: last captured data bit, held until the next capture.
REQ-009 Port bitValid SHALL be an output, 1 bit wide: a one-cycle pulse on each capture.
REQ-010 Port history SHALL be an output, 4 bits wide: last four captured bits, newest in bit 0.
REQ-011 Port bitCount SHALL be an output, 8 bits wide: number of captures, modulo 256.

Function
REQ-012 dataSw and shiftBtn SHALL each pass through a 2-flop synchronizer before any other logic.
REQ-013 Each synchronized input SHALL have its own debouncer: a stable register and a CNT_W-bit counter.
REQ-014 Debouncer: if sync == stable, the counter SHALL clear to 0.
REQ-015 Debouncer: if sync != stable, the counter SHALL increment; on the cycle the count would reach DEBOUNCE_CYCLES, stable SHALL take sync and the counter SHALL clear.
REQ-016 Any glitch shorter than DEBOUNCE_CYCLES consecutive cycles SHALL leave stable unchanged; a mismatch that ends restarts the count from 0.
REQ-017 The capture FSM SHALL have three states: WAIT_PRESS (reset state), CAPTURE, WAIT_RELEASE.
REQ-018 From WAIT_PRESS, the FSM SHALL move to CAPTURE when the debounced button is 1; otherwise it SHALL stay.
REQ-019 CAPTURE SHALL last exactly one cycle and then go to WAIT_RELEASE.
REQ-020 In CAPTURE, bitValid SHALL be 1; at the end of that cycle bitOut SHALL take the debounced data, history SHALL become {history[2:0], debounced data}, and bitCount SHALL increment (255 wraps to 0).
REQ-021 bitValid SHALL be driven combinationally from state == CAPTURE and SHALL be 0 in every other state.
REQ-022 From WAIT_RELEASE, the FSM SHALL go to WAIT_PRESS when the debounced button is 0.
REQ-023 A held button SHALL produce exactly one capture.
REQ-024 Capture SHALL use the debounced data level sampled in the CAPTURE cycle; a data change in the same cycle as a button change SHALL be seen only after its own debounce.
REQ-025 Latency: raw shiftBtn held high continuously -> bitValid high on clock edge DEBOUNCE_CYCLES+3 after the first sampling edge, ±0 cycles.
REQ-026 Unused FSM encodings SHALL go to WAIT_PRESS on the next edge.

Reset
REQ-027 While Rst is 1 at a clock edge, synchronizers, stable registers and counters SHALL clear to 0, the FSM SHALL go to WAIT_PRESS, and bitOut, history and bitCount SHALL go to 0; bitValid SHALL be 0 in the cycle after reset.
REQ-028 Reset SHALL take priority over every other event, including a capture in progress.
REQ-029 If the button is held through reset release, it SHALL re-debounce from 0 and yield one capture DEBOUNCE_CYCLES+3 edges after release.

Verification (DEBOUNCE_CYCLES=4)
REQ-030 Clean press: dataSw=1 held; shiftBtn raised for 20 cycles -> one bitValid pulse at edge 7; bitOut=1, history=0001, bitCount=1.
REQ-031 Glitch rejection: shiftBtn high for 3 cycles, low, then high for 3 cycles -> no bitValid, state stays WAIT_PRESS.
REQ-032 Pattern feed: presses with data 1,1,0,1, each held 10 cycles with 10-cycle gaps -> four pulses, history=1101, bitCount=4.
REQ-033 Wrap: 256 presses -> bitCount=0 after the last pulse; 257th press -> bitCount=1.
REQ-034 Reset mid-hold: Rst for 1 cycle in WAIT_RELEASE with the button still held -> outputs 0, then one new pulse 7 edges after reset release.
REQ-035 Data bounce: dataSw toggles every 2 cycles during a press, from a settled 0 -> bitOut=0 captured.

Source files
------------

// File: rtl/button_bit_sampler.sv
// Button-driven serial bit entry. Two raw switch inputs are synchronised and
// debounced. Each debounced button press captures the debounced data level
// into bitOut, shifts it into a 4-bit history and bumps a capture counter.
// CNT_W must satisfy 2**CNT_W > DEBOUNCE_CYCLES.
module button_bit_sampler #(
  parameter int DEBOUNCE_CYCLES = 1250000,
  parameter int CNT_W           = 21
) (
  input  logic       CLOCK,
  input  logic       Rst,
  input  logic       dataSw,
  input  logic       shiftBtn,
  output logic       bitOut,
  output logic       bitValid,
  output logic [3:0] history,
  output logic [7:0] bitCount
);

  typedef enum logic [1:0] {
    WAIT_PRESS   = 2'b00,
    CAPTURE      = 2'b01,
    WAIT_RELEASE = 2'b10
  } state_e;

  // A mismatch is accepted on the cycle the count would reach DEBOUNCE_CYCLES,
  // i.e. when the current count already equals DEBOUNCE_CYCLES-1.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             data_meta_q, data_sync_q;
  logic             btn_meta_q, btn_sync_q;
  logic             data_stable_q, data_stable_d;
  logic             btn_stable_q, btn_stable_d;
  logic [CNT_W-1:0] data_cnt_q, data_cnt_d;
  logic [CNT_W-1:0] btn_cnt_q, btn_cnt_d;
  state_e           state_q;
  logic             bit_out_q;
  logic [3:0]       history_q;
  logic [7:0]       bit_count_q;

  // Two-flop synchronisers for both raw inputs.
  // NOTE: reset here is synchronous (sampled on the clock edge), so Rst itself
  // must already be synchronous to CLOCK; no async reset path exists.
  always_ff @(posedge CLOCK) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (Rst) begin
      data_meta_q <= 1'b0;
      data_sync_q <= 1'b0;
      btn_meta_q  <= 1'b0;
      btn_sync_q  <= 1'b0;
    end else begin
      data_meta_q <= dataSw;
      data_sync_q <= data_meta_q;
      btn_meta_q  <= shiftBtn;
      btn_sync_q  <= btn_meta_q;
    end
  end

  // Data debouncer next state: count consecutive mismatches, accept at the limit.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave it unassigned and infer a latch.
    data_stable_d = data_stable_q;
    data_cnt_d    = '0;
    if (data_sync_q != data_stable_q) begin
      if (data_cnt_q == CNT_LAST) begin
        data_stable_d = data_sync_q;
      end else begin
        data_cnt_d = data_cnt_q + CNT_ONE;
      end
    end
  end

  // Button debouncer next state: same rule as the data debouncer.
  always_comb begin
    btn_stable_d = btn_stable_q;
    btn_cnt_d    = '0;
    if (btn_sync_q != btn_stable_q) begin
      if (btn_cnt_q == CNT_LAST) begin
        btn_stable_d = btn_sync_q;
      end else begin
        btn_cnt_d = btn_cnt_q + CNT_ONE;
      end
    end
  end

  // Debouncer state registers.
  always_ff @(posedge CLOCK) begin
    if (Rst) begin
      data_stable_q <= 1'b0;
      data_cnt_q    <= '0;
      btn_stable_q  <= 1'b0;
      btn_cnt_q     <= '0;
    end else begin
      data_stable_q <= data_stable_d;
      data_cnt_q    <= data_cnt_d;
      btn_stable_q  <= btn_stable_d;
      btn_cnt_q     <= btn_cnt_d;
    end
  end

  // Capture FSM with registered bit, history and count; one capture per press.
  always_ff @(posedge CLOCK) begin
    if (Rst) begin
      state_q     <= WAIT_PRESS;
      bit_out_q   <= 1'b0;
      history_q   <= 4'h0;
      bit_count_q <= 8'h00;
    end else begin
      case (state_q)
        WAIT_PRESS: begin
          if (btn_stable_q) state_q <= CAPTURE;
        end
        CAPTURE: begin
          state_q     <= WAIT_RELEASE;
          bit_out_q   <= data_stable_q;
          history_q   <= {history_q[2:0], data_stable_q};
          bit_count_q <= bit_count_q + 8'd1;
        end
        WAIT_RELEASE: begin
          if (!btn_stable_q) state_q <= WAIT_PRESS;
        end
        default: state_q <= WAIT_PRESS;
      endcase
    end
  end

  // The capture strobe is decoded straight from the state so it coincides
  // with the CAPTURE cycle.
  assign bitValid = (state_q == CAPTURE);
  assign bitOut   = bit_out_q;
  assign history  = history_q;
  assign bitCount = bit_count_q;

endmodule

// File: tb/tb_button_bit_sampler.sv
// Self-checking bench for button_bit_sampler with a short debounce window.
module tb_button_bit_sampler;

  localparam int D = 4;

  logic       CLOCK;
  logic       Rst;
  logic       dataSw;
  logic       shiftBtn;
  logic       bitOut;
  logic       bitValid;
  logic [3:0] history;
  logic [7:0] bitCount;

  int n_vec  = 0;
  int n_bad  = 0;
  int pulses = 0;

  button_bit_sampler #(
    .DEBOUNCE_CYCLES(D),
    .CNT_W          (3)
  ) dut (
    .CLOCK   (CLOCK),
    .Rst     (Rst),
    .dataSw  (dataSw),
    .shiftBtn(shiftBtn),
    .bitOut  (bitOut),
    .bitValid(bitValid),
    .history (history),
    .bitCount(bitCount)
  );

  initial begin
    CLOCK = 1'b0;
    forever #5 CLOCK = ~CLOCK;
  end

  // Reference model: each input is seen two edges late; a level is accepted
  // once the last D synchronised samples all disagree with the accepted level.
  // A capture strobe follows one cycle after the debounced button rises, and
  // the registers update at the end of the strobe cycle.
  logic       m_s1d, m_s2d, m_s1b, m_s2b;
  logic [D-1:0] m_win_d, m_win_b;
  logic       m_std, m_stb, m_rose, m_valid, m_bit;
  logic [3:0] m_hist;
  logic [7:0] m_cnt;

  task automatic model_edge();
    logic old_b;
    if (Rst) begin
      {m_s1d, m_s2d, m_s1b, m_s2b} = '0;
      m_win_d = '0;
      m_win_b = '0;
      {m_std, m_stb, m_rose, m_valid, m_bit} = '0;
      m_hist = '0;
      m_cnt  = '0;
    end else begin
      if (m_valid) begin
        m_bit  = m_std;
        m_hist = {m_hist[2:0], m_std};
        m_cnt  = m_cnt + 8'd1;
      end
      m_valid = m_rose;
      m_win_d = {m_win_d[D-2:0], m_s2d};
      m_win_b = {m_win_b[D-2:0], m_s2b};
      old_b   = m_stb;
      if (m_win_d == {D{~m_std}}) m_std = ~m_std;
      if (m_win_b == {D{~m_stb}}) m_stb = ~m_stb;
      m_rose = m_stb && !old_b;
      m_s2d  = m_s1d;
      m_s1d  = dataSw;
      m_s2b  = m_s1b;
      m_s1b  = shiftBtn;
    end
  endtask

  task automatic check(input string name, input logic [31:0] actual,
                       input logic [31:0] expected);
    n_vec++;
    if (actual !== expected) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, actual, expected);
    end
  endtask

  // One clock edge: advance the model, then sample outputs 1 time unit later.
  task automatic tick();
    @(posedge CLOCK);
    model_edge();
    #1;
    if (bitValid === 1'b1) pulses++;
  endtask

  task automatic cycle();
    tick();
    check("model", 32'({bitValid, bitOut, history, bitCount}),
          32'({m_valid, m_bit, m_hist, m_cnt}));
  endtask

  task automatic do_reset();
    Rst = 1'b1;
    cycle();
    Rst = 1'b0;
  endtask

  task automatic press(input logic d, input int hold, input int gap);
    dataSw   = d;
    shiftBtn = 1'b1;
    repeat (hold) cycle();
    shiftBtn = 1'b0;
    repeat (gap) cycle();
  endtask

  typedef struct {
    logic       rst;
    logic       data;
    logic       btn;
    logic       exp_valid;
    logic       exp_bit;
    logic [3:0] exp_hist;
    logic [7:0] exp_cnt;
  } vector_t;

  vector_t vecs [13];

  initial begin
    int p0;
    int lat;

    // Clean press from reset: strobe at edge 7, registers updated from edge 8.
    vecs[0] = '{rst: 1'b1, data: 1'b1, btn: 1'b0, exp_valid: 1'b0,
                exp_bit: 1'b0, exp_hist: 4'h0, exp_cnt: 8'h00};
    for (int i = 1; i < 13; i++) begin
      vecs[i] = '{rst: 1'b0, data: 1'b1, btn: 1'b1, exp_valid: (i == 7),
                  exp_bit: (i >= 8), exp_hist: (i >= 8) ? 4'h1 : 4'h0,
                  exp_cnt: (i >= 8) ? 8'h01 : 8'h00};
    end

    Rst      = 1'b1;
    dataSw   = 1'b0;
    shiftBtn = 1'b0;

    for (int i = 0; i < 13; i++) begin
      Rst      = vecs[i].rst;
      dataSw   = vecs[i].data;
      shiftBtn = vecs[i].btn;
      tick();
      check($sformatf("table[%0d]", i),
            32'({bitValid, bitOut, history, bitCount}),
            32'({vecs[i].exp_valid, vecs[i].exp_bit, vecs[i].exp_hist, vecs[i].exp_cnt}));
    end
    shiftBtn = 1'b0;
    repeat (10) cycle();

    // Glitch rejection: two 3-cycle bursts never become a press.
    dataSw = 1'b1;
    do_reset();
    p0 = pulses;
    shiftBtn = 1'b1; repeat (3) cycle();
    shiftBtn = 1'b0; repeat (1) cycle();
    shiftBtn = 1'b1; repeat (3) cycle();
    shiftBtn = 1'b0; repeat (12) cycle();
    check("glitch_pulses", 32'(pulses - p0), 32'd0);
    check("glitch_count", 32'(bitCount), 32'd0);

    // Pattern feed 1,1,0,1 with data changing together with the button.
    do_reset();
    p0 = pulses;
    press(1'b1, 10, 10);
    press(1'b1, 10, 10);
    press(1'b0, 10, 10);
    press(1'b1, 10, 10);
    check("pattern_pulses", 32'(pulses - p0), 32'd4);
    check("pattern_history", 32'(history), 32'hD);
    check("pattern_count", 32'(bitCount), 32'd4);

    // Counter wrap: 256 presses return to 0, one more gives 1.
    do_reset();
    p0 = pulses;
    for (int i = 0; i < 256; i++) press(1'(i & 1), 10, 10);
    check("wrap_pulses", 32'(pulses - p0), 32'd256);
    check("wrap_count256", 32'(bitCount), 32'd0);
    press(1'b1, 10, 10);
    check("wrap_count257", 32'(bitCount), 32'd1);

    // Reset while held in WAIT_RELEASE: outputs clear, one new strobe 7 edges later.
    do_reset();
    dataSw   = 1'b1;
    shiftBtn = 1'b1;
    repeat (12) cycle();
    check("midhold_precount", 32'(bitCount), 32'd1);
    Rst = 1'b1;
    cycle();
    Rst = 1'b0;
    check("midhold_outputs", 32'({bitValid, bitOut, history, bitCount}), 32'd0);
    lat = 0;
    for (int e = 1; e <= 20; e++) begin
      cycle();
      if (bitValid === 1'b1) begin
        lat = e;
        break;
      end
    end
    check("midhold_latency", 32'(lat), 32'd7);
    repeat (10) cycle();
    check("midhold_single", 32'(bitCount), 32'd1);
    shiftBtn = 1'b0;
    repeat (10) cycle();

    // Data bounce during a press from a settled 0 captures 0.
    do_reset();
    press(1'b1, 10, 10);
    dataSw = 1'b0;
    repeat (10) cycle();
    shiftBtn = 1'b1;
    for (int i = 0; i < 6; i++) begin
      repeat (2) cycle();
      dataSw = ~dataSw;
    end
    shiftBtn = 1'b0;
    dataSw   = 1'b0;
    repeat (10) cycle();
    check("bounce_bit", 32'(bitOut), 32'd0);
    check("bounce_count", 32'(bitCount), 32'd2);
    check("bounce_history", 32'(history), 32'h2);

    // Randomised segments of held levels, short glitches and occasional resets.
    for (int s = 0; s < 300; s++) begin
      dataSw   = 1'($urandom_range(0, 1));
      shiftBtn = 1'($urandom_range(0, 1));
      Rst      = ($urandom_range(0, 39) == 0);
      if (Rst) begin
        cycle();
        Rst = 1'b0;
      end else begin
        repeat ($urandom_range(1, 10)) cycle();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
